// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin AXI4-Lite write-channel arbiter: a single master owns the slave
// from AW/W issue until its B handshake completes, so writes never interleave.
module axi_lite_wr_arbiter #(
   parameter int  N_MASTERS = 2,
   parameter int  ADDR_W    = 32,
   parameter int  DATA_W    = 32,
   localparam int STRB_W    = DATA_W / 8,
   localparam int IDX_W     = $clog2(N_MASTERS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_MASTERS-1:0]          m_awvalid,
   output logic [N_MASTERS-1:0]          m_awready,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
   input  logic [N_MASTERS*3-1:0]        m_awprot,
   input  logic [N_MASTERS-1:0]          m_wvalid,
   output logic [N_MASTERS-1:0]          m_wready,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
   output logic [N_MASTERS-1:0]          m_bvalid,
   input  logic [N_MASTERS-1:0]          m_bready,
   output logic [N_MASTERS*2-1:0]        m_bresp,
   output logic                          s_awvalid,
   input  logic                          s_awready,
   output logic [ADDR_W-1:0]             s_awaddr,
   output logic [2:0]                    s_awprot,
   output logic                          s_wvalid,
   input  logic                          s_wready,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [STRB_W-1:0]             s_wstrb,
   input  logic                          s_bvalid,
   output logic                          s_bready,
   input  logic [1:0]                    s_bresp,
   output logic                          grant_valid,
   output logic [IDX_W-1:0]              grant_idx
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]     prio_ptr_q, prio_ptr_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;

   logic [N_MASTERS-1:0] req;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     next_ptr;
   logic                 aw_hs, w_hs, b_hs;

   assign req = m_awvalid | m_wvalid;

   // Rotating search: the first requester at or after prio_ptr wins.
   always_comb begin : rr_pick
      int cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         cand = int'(prio_ptr_q) + k;
         if (cand >= N_MASTERS) cand = cand - N_MASTERS;
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // The master just served drops to lowest priority.
   assign next_ptr = (grant_idx_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign b_hs  = s_bvalid & s_bready;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      prio_ptr_d  = prio_ptr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_idx_d = pick_idx;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               state_d     = ST_XFER;
            end
         end
         ST_XFER: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (b_hs) begin
               prio_ptr_d  = next_ptr;
               grant_idx_d = '0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            grant_idx_d = '0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign grant_valid = (state_q != ST_IDLE);
   assign grant_idx   = grant_idx_q;

   // Only the granted master is connected; everyone else sees idle handshakes.
   always_comb begin
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_awprot  = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_bready  = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant_valid && grant_idx_q == IDX_W'(i)) begin
            s_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
            s_awprot = m_awprot[i*3 +: 3];
            s_wdata  = m_wdata[i*DATA_W +: DATA_W];
            s_wstrb  = m_wstrb[i*STRB_W +: STRB_W];
            if (state_q == ST_XFER) begin
               s_awvalid    = m_awvalid[i] & ~aw_done_q;
               s_wvalid     = m_wvalid[i] & ~w_done_q;
               m_awready[i] = s_awready & ~aw_done_q;
               m_wready[i]  = s_wready & ~w_done_q;
            end
            if (state_q == ST_RESP) begin
               m_bvalid[i]       = s_bvalid;
               m_bresp[i*2 +: 2] = s_bresp;
               s_bready          = m_bready[i];
            end
         end
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
         prio_ptr_q  <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         prio_ptr_q  <= prio_ptr_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Self-checking bench for axi_lite_wr_arbiter: directed scenarios plus a random
// phase, every cycle compared against a transaction-ownership reference model.
module tb_axi_lite_wr_arbiter;

   localparam int  N    = 3;
   localparam int  AW   = 32;
   localparam int  DW   = 32;
   localparam int  SW   = DW / 8;
   localparam int  IW   = $clog2(N);
   localparam time HALF = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [N*AW-1:0]   m_awaddr;
   logic [N*3-1:0]    m_awprot;
   logic [N*DW-1:0]   m_wdata;
   logic [N*SW-1:0]   m_wstrb;
   logic [N*2-1:0]    m_bresp;
   logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [AW-1:0]     s_awaddr;
   logic [2:0]        s_awprot;
   logic [DW-1:0]     s_wdata;
   logic [SW-1:0]     s_wstrb;
   logic [1:0]        s_bresp;
   logic              grant_valid;
   logic [IW-1:0]     grant_idx;
   logic [127:0]      all_outs;

   always #HALF clk = ~clk;

   axi_lite_wr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .grant_valid(grant_valid), .grant_idx(grant_idx)
   );

   assign all_outs = 128'({grant_valid, grant_idx, s_awvalid, s_awaddr, s_awprot, s_wvalid,
                           s_wdata, s_wstrb, s_bready, m_awready, m_wready, m_bvalid, m_bresp});

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          mst;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [2:0]  prot;
      int          aw_dly;
      int          w_dly;
      int          b_hold;
   } txn_t;

   // Master-side drivers
   txn_t pend[$];
   txn_t cur[N];
   bit   act[N], aw_sent[N], w_sent[N];
   int   aw_left[N], w_left[N], b_left[N];
   bit   rand_mode = 1'b0;

   // Slave-side driver
   bit   sl_aw, sl_w;
   int   sl_bdly, aw_stall;
   logic [1:0] sl_bresp;

   // Reference model: who owns the slave, which halves of the write it has seen, whose turn is next
   int   own, ptr;
   bit   aw_seen, w_seen;
   logic          e_gv, e_awv, e_wv, e_bready;
   logic [IW-1:0] e_gidx;
   logic [N-1:0]  e_awr, e_wr, e_bv;
   logic [2*N-1:0] e_bresp;
   logic [AW-1:0] e_addr;
   logic [2:0]    e_prot;
   logic [DW-1:0] e_data;
   logic [SW-1:0] e_strb;

   // Observations taken from the DUT for directed ordering checks
   logic [AW-1:0] aw_log[$];
   logic [DW-1:0] w_log[$];
   int   g_log[$], g_cyc[$], b_cyc[$];
   bit   gv_prev;
   int   cyc;

   function automatic txn_t mk(int m, logic [AW-1:0] a, logic [DW-1:0] d, int awd, int wd, int bh);
      txn_t t;
      t.mst = m; t.addr = a; t.data = d; t.strb = '1; t.prot = 3'd0;
      t.aw_dly = awd; t.w_dly = wd; t.b_hold = bh;
      return t;
   endfunction

   function automatic txn_t rand_txn(int m);
      txn_t t;
      t.mst = m; t.addr = $urandom; t.data = $urandom; t.strb = SW'($urandom); t.prot = 3'($urandom);
      t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3); t.b_hold = $urandom_range(0, 2);
      return t;
   endfunction

   task automatic drive();
      bit got;
      for (int i = 0; i < N; i++) begin
         if (!act[i]) begin
            got = 1'b0;
            for (int j = 0; j < pend.size(); j++) begin
               if (!got && pend[j].mst == i) begin
                  cur[i] = pend[j];
                  pend.delete(j);
                  got = 1'b1;
                  act[i] = 1'b1; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
                  aw_left[i] = cur[i].aw_dly; w_left[i] = cur[i].w_dly; b_left[i] = cur[i].b_hold;
               end
            end
         end
         if (act[i]) begin
            m_awvalid[i] = !aw_sent[i] && aw_left[i] == 0;
            m_wvalid[i]  = !w_sent[i] && w_left[i] == 0;
            m_bready[i]  = aw_sent[i] && w_sent[i] && b_left[i] == 0;
            m_awaddr[i*AW +: AW] = cur[i].addr;
            m_awprot[i*3 +: 3]   = cur[i].prot;
            m_wdata[i*DW +: DW]  = cur[i].data;
            m_wstrb[i*SW +: SW]  = cur[i].strb;
         end else begin
            m_awvalid[i] = 1'b0;
            m_wvalid[i]  = 1'b0;
            m_bready[i]  = rand_mode ? 1'($urandom) : 1'b0;
            m_awaddr[i*AW +: AW] = rand_mode ? AW'($urandom) : '0;
            m_awprot[i*3 +: 3]   = rand_mode ? 3'($urandom) : '0;
            m_wdata[i*DW +: DW]  = rand_mode ? DW'($urandom) : '0;
            m_wstrb[i*SW +: SW]  = rand_mode ? SW'($urandom) : '0;
         end
      end
      s_awready = rand_mode ? 1'($urandom) : (aw_stall == 0);
      s_wready  = rand_mode ? 1'($urandom) : 1'b1;
      if (sl_aw && sl_w && sl_bdly == 0) begin
         s_bvalid = 1'b1; s_bresp = sl_bresp;
      end else if (rand_mode && !(sl_aw && sl_w) && $urandom_range(0, 7) == 0) begin
         s_bvalid = 1'b1; s_bresp = 2'($urandom);
      end else begin
         s_bvalid = 1'b0; s_bresp = rand_mode ? 2'($urandom) : 2'd0;
      end
   endtask

   task automatic eval_cycle();
      logic aw_hs, w_hs, b_hs, in_resp;
      logic [N-1:0] req;
      bit found;
      int c;
      // DUT-side observations
      if (s_awvalid && s_awready) aw_log.push_back(s_awaddr);
      if (s_wvalid && s_wready) w_log.push_back(s_wdata);
      if (s_bvalid && s_bready) b_cyc.push_back(cyc);
      if (grant_valid && !gv_prev) begin
         g_log.push_back(int'(grant_idx));
         g_cyc.push_back(cyc);
      end
      gv_prev = grant_valid;

      // Expected outputs from the ownership model
      e_gv = 1'b0; e_gidx = '0; e_awv = 1'b0; e_wv = 1'b0; e_bready = 1'b0;
      e_awr = '0; e_wr = '0; e_bv = '0; e_bresp = '0;
      e_addr = '0; e_prot = '0; e_data = '0; e_strb = '0;
      in_resp = (own >= 0) && aw_seen && w_seen;
      if (own >= 0) begin
         e_gv = 1'b1; e_gidx = IW'(own);
         e_addr = m_awaddr[own*AW +: AW]; e_prot = m_awprot[own*3 +: 3];
         e_data = m_wdata[own*DW +: DW];  e_strb = m_wstrb[own*SW +: SW];
         if (!in_resp) begin
            e_awv = m_awvalid[own] && !aw_seen;
            e_wv  = m_wvalid[own] && !w_seen;
            e_awr[own] = s_awready && !aw_seen;
            e_wr[own]  = s_wready && !w_seen;
         end else begin
            e_bv[own] = s_bvalid;
            e_bresp[own*2 +: 2] = s_bresp;
            e_bready = m_bready[own];
         end
      end

      check("grant", 128'({grant_valid, grant_idx}), 128'({e_gv, e_gidx}));
      check("s_aw", 128'({s_awvalid, s_awaddr, s_awprot}), 128'({e_awv, e_addr, e_prot}));
      check("s_w", 128'({s_wvalid, s_wdata, s_wstrb}), 128'({e_wv, e_data, e_strb}));
      check("s_bready", 128'(s_bready), 128'(e_bready));
      check("m_ready", 128'({m_awready, m_wready}), 128'({e_awr, e_wr}));
      check("m_b", 128'({m_bvalid, m_bresp}), 128'({e_bv, e_bresp}));

      aw_hs = e_awv && s_awready;
      w_hs  = e_wv && s_wready;
      b_hs  = in_resp && s_bvalid && e_bready;

      for (int i = 0; i < N; i++) begin
         if (act[i]) begin
            if (aw_sent[i] && w_sent[i] && b_left[i] > 0) b_left[i]--;
            if (m_awvalid[i] && e_awr[i]) aw_sent[i] = 1'b1;
            if (m_wvalid[i] && e_wr[i]) w_sent[i] = 1'b1;
            if (m_bready[i] && e_bv[i]) act[i] = 1'b0;
            if (aw_left[i] > 0) aw_left[i]--;
            if (w_left[i] > 0) w_left[i]--;
         end
      end

      if (!rand_mode && e_awv && !s_awready && aw_stall > 0) aw_stall--;
      if (b_hs) begin
         sl_aw = 1'b0; sl_w = 1'b0;
      end else if (sl_aw && sl_w) begin
         if (sl_bdly > 0) sl_bdly--;
      end else begin
         if (aw_hs) sl_aw = 1'b1;
         if (w_hs) sl_w = 1'b1;
         if (sl_aw && sl_w) begin
            sl_bdly  = rand_mode ? $urandom_range(0, 2) : 0;
            sl_bresp = rand_mode ? 2'($urandom) : 2'd0;
         end
      end

      if (own < 0) begin
         req = m_awvalid | m_wvalid;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (!found && req[c]) begin
               found = 1'b1;
               own = c;
            end
         end
         aw_seen = 1'b0; w_seen = 1'b0;
      end else if (!in_resp) begin
         aw_seen = aw_seen | aw_hs;
         w_seen  = w_seen | w_hs;
      end else if (b_hs) begin
         ptr = (own + 1) % N;
         own = -1;
      end
      cyc++;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      eval_cycle();
   endtask

   task automatic wait_done(input int max_cycles);
      bit busy;
      int n;
      n = 0;
      busy = 1'b1;
      while (busy && n < max_cycles) begin
         cycle();
         n++;
         busy = (pend.size() != 0) || (own >= 0);
         for (int i = 0; i < N; i++) if (act[i]) busy = 1'b1;
      end
      check("done_in_budget", 128'(busy), 128'(0));
      cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_awvalid = '0; m_wvalid = '0; m_bready = '0;
      m_awaddr = '0; m_awprot = '0; m_wdata = '0; m_wstrb = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'd0;
      pend.delete();
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
         aw_left[i] = 0; w_left[i] = 0; b_left[i] = 0;
      end
      sl_aw = 1'b0; sl_w = 1'b0; sl_bdly = 0; sl_bresp = 2'd0; aw_stall = 0;
      own = -1; ptr = 0; aw_seen = 1'b0; w_seen = 1'b0;
      aw_log.delete(); w_log.delete(); g_log.delete(); g_cyc.delete(); b_cyc.delete();
      gv_prev = 1'b0; cyc = 0;
      #1;
      check("reset_values", all_outs, 128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Single write from master 0
      do_reset();
      pend.push_back(mk(0, 32'h4000_0004, 32'hDEAD_BEEF, 0, 0, 0));
      wait_done(50);
      check("t1_aw_addr", 128'(aw_log[0]), 128'(32'h4000_0004));
      check("t1_w_data", 128'(w_log[0]), 128'(32'hDEAD_BEEF));
      check("t1_grant_idx", 128'(g_log[0]), 128'(0));
      check("t1_grant_latency", 128'(g_cyc[0]), 128'(1));
      check("t1_n_grants", 128'(g_log.size()), 128'(1));

      // Simultaneous requests after reset
      do_reset();
      pend.push_back(mk(0, 32'h4000_0010, 32'h1111_1111, 0, 0, 0));
      pend.push_back(mk(1, 32'h4000_0020, 32'h2222_2222, 0, 0, 0));
      wait_done(50);
      check("t2_n_aw", 128'(aw_log.size()), 128'(2));
      check("t2_n_w", 128'(w_log.size()), 128'(2));
      check("t2_aw0", 128'(aw_log[0]), 128'(32'h4000_0010));
      check("t2_aw1", 128'(aw_log[1]), 128'(32'h4000_0020));
      check("t2_w0", 128'(w_log[0]), 128'(32'h1111_1111));
      check("t2_w1", 128'(w_log[1]), 128'(32'h2222_2222));
      check("t2_idle_gap", 128'(g_cyc[1] - b_cyc[0]), 128'(2));

      // Fairness: m0 back-to-back, m1 pending from the start
      do_reset();
      for (int k = 0; k < 3; k++) pend.push_back(mk(0, 32'h4000_0100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 0, 0, 0));
      pend.push_back(mk(1, 32'h4000_0200, 32'hB000_0000, 0, 0, 0));
      wait_done(100);
      check("t3_order", 128'({8'(g_log[0]), 8'(g_log[1]), 8'(g_log[2]), 8'(g_log[3])}), 128'(32'h00_01_00_00));
      check("t3_n_grants", 128'(g_log.size()), 128'(4));

      // W before AW, slave stalls AW
      do_reset();
      aw_stall = 2;
      pend.push_back(mk(1, 32'h4000_0300, 32'hC0FF_EE00, 3, 0, 0));
      wait_done(50);
      check("t4_n_aw", 128'(aw_log.size()), 128'(1));
      check("t4_n_w", 128'(w_log.size()), 128'(1));
      check("t4_grant", 128'(g_log[0]), 128'(1));

      // B backpressure with m1 waiting
      do_reset();
      pend.push_back(mk(0, 32'h4000_0400, 32'h1234_5678, 0, 0, 4));
      pend.push_back(mk(1, 32'h4000_0500, 32'h8765_4321, 0, 0, 0));
      wait_done(60);
      check("t5_order", 128'({8'(g_log[0]), 8'(g_log[1])}), 128'(16'h00_01));
      check("t5_gap", 128'(g_cyc[1] - b_cyc[0]), 128'(2));

      // Reset while m1 is in XFER with AW done, W pending
      do_reset();
      pend.push_back(mk(0, 32'h4000_0600, 32'h5555_0000, 0, 0, 0));
      wait_done(50);
      pend.push_back(mk(1, 32'h4000_0700, 32'h6666_0000, 0, 6, 0));
      for (int k = 0; k < 10 && !(act[1] && aw_sent[1]); k++) cycle();
      check("t6_aw_done_before_reset", 128'(aw_sent[1]), 128'(1));
      check("t6_granted_before_reset", 128'({grant_valid, grant_idx}), 128'({1'b1, IW'(1)}));
      @(posedge clk);
      #1;
      drive();
      #2 rst_n = 1'b0;
      #1;
      check("t6_outputs_in_reset", all_outs, 128'(0));
      do_reset();
      pend.push_back(mk(1, 32'h4000_0800, 32'h7777_0000, 0, 0, 0));
      pend.push_back(mk(0, 32'h4000_0900, 32'h8888_0000, 0, 0, 0));
      wait_done(60);
      check("t6_first_after_reset", 128'(g_log[0]), 128'(0));

      // Random traffic with random slave readiness and spurious B
      do_reset();
      rand_mode = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (pend.size() < 8 && $urandom_range(0, 4) == 0) pend.push_back(rand_txn($urandom_range(0, N - 1)));
         cycle();
      end
      wait_done(3000);
      rand_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
